vga_frame_scanner: RTL
======================

# vga_frame_scanner

Scans the 640×480 pixel framebuffer that the character writer fills, fetching one 3-bit colour per pixel and driving the VGA DAC with standard 640×480@60 Hz timing. It sits directly downstream of the framebuffer write side, on the framebuffer's read port. It exports a frame-start pulse and a vertical-blank level so upstream writers can pace their updates.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (ticks)
- H_SYNC, 96, horizontal sync width (ticks)
- H_BP, 48, horizontal back porch (ticks)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)

- clock  in  1  system clock; one clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- pixel_enable  in  1  pixel tick qualifier (25 MHz rate); state advances only when high
- mem_raddr  out  19  framebuffer read address, y*640+x
- mem_rdata  in  3  framebuffer data; valid one clock after mem_raddr
- vga_hs  out  1  horizontal sync, active-low
- vga_vs  out  1  vertical sync, active-low
- vga_blank_n  out  1  high during visible pixels
- vga_sync_n  out  1  tied 0
- vga_r, vga_g, vga_b  out  8 each  colour channels
- frame_start  out  1  one-clock pulse at frame wrap
- vblank  out  1  high while the line counter is ≥ V_ACTIVE

## Operation
- Counters:
  - h_count runs 0..H_TOTAL-1, where H_TOTAL = 800.
  - v_count runs 0..V_TOTAL-1, where V_TOTAL = 525.
  - Both advance only on clocks with pixel_enable=1.
  - When h wraps from 799 to 0, v increments. When v wraps from 524 to 0, the frame restarts.
- Active region: h < 640 and v < 480.
- Sync regions, computed on counter stage:
  - Horizontal sync is low for h in 656..751.
  - Vertical sync is low for v in 490..491.
- Address generation:
  - mem_raddr always equals the linear index of the current (h,v) while in the active region.
  - Outside the active region it holds its last value.
  - It is 0 at (0,0).
  - The multiplier-free form is required: increment by 1 per active tick, and load 0 at frame wrap.
  - The maximum value is 307199, which fits in 19 bits. There is no overflow case.
- Colour expansion:
  - mem_rdata bit2 drives R, bit1 drives G, bit0 drives B.
  - Each bit expands to 8'hFF when 1 and 8'h00 when 0.
  - Outside the active region all channels are forced to 0.
- Output pipeline:
  - Stage 0 holds the counters and address.
  - Stage 1 holds the registered vga_hs/vs/blank_n/rgb, loaded on pixel_enable.
  - Sync and blank are delayed one tick so they align with the RAM data.
- frame_start:
  - Asserted for exactly one clock, on the clock where pixel_enable=1 and (h,v)=(799,524). The counters show (0,0) on the next clock.
- vblank:
  - Combinational from v_count ≥ 480. It is not pipelined.
- Reset:
  - Counters and mem_raddr go to 0.
  - vga_hs and vga_vs go to 1.
  - vga_blank_n, all rgb channels and frame_start go to 0.
  - vblank follows v_count, so it is 0.
  - Reset overrides pixel_enable.
  - A reset mid-frame restarts at (0,0) on the next clock. There is no partial-line recovery.

## Timing
- Pixel latency: mem_raddr for pixel (x,y) is presented on tick n. vga_rgb/blank_n/hs/vs for that pixel appear after tick n+1's enable edge, a fixed latency of 1 pixel tick.
- pixel_enable low: all registers hold, including the outputs and mem_raddr. frame_start stays 0.
- Frame period: 420000 pixel ticks. Line period: 800 ticks.
- Simultaneous frame wrap and reset: reset wins and frame_start stays 0.
- The RAM read port must have a registered address with 1-clock latency. pixel_enable must be low for at least 1 clock between highs (at most every other clock).

## Test plan
- Reset:
  - Stimulus: assert reset for 3 clocks, with pixel_enable toggling.
  - Required: mem_raddr=0, vga_hs=vga_vs=1, blank_n=0, rgb=0, frame_start=0, vblank=0.
- Line 0 addressing:
  - Stimulus: after reset, alternate pixel_enable.
  - Required: mem_raddr goes 0,1,…,639, then holds 639 for 160 ticks, then is 640 at line 1, x=0.
- Sync placement:
  - Required: vga_hs is low for exactly 96 ticks, starting on the output edge of tick 657 counting from h=0.
  - Required: vga_vs is low for 2 lines, starting at line 490 plus 1 tick.
- Colour path:
  - Stimulus: model RAM returns 3'b101 for address 5 and 0 elsewhere.
  - Required: output at the tick after address 5 is R=FF, G=00, B=FF, blank_n=1. Neighbouring pixels are 0.
- Frame pulse:
  - Required: frame_start pulses once per 420000 ticks, each pulse one clock wide.
  - Required: vblank rises at v=480 and falls at wrap.
  - Required: mem_raddr reads 0 on the clock after frame_start.
- Stall and mid-frame reset:
  - Stimulus: hold pixel_enable=0 for 50 clocks mid-line.
  - Required: all outputs frozen.
  - Stimulus: then pulse reset at (h=300,v=200).
  - Required: counters return to (0,0), and mem_raddr=0 on the next clock.

Source files
------------

// File: rtl/vga_frame_scanner.sv
// vga_frame_scanner: 640x480@60 framebuffer scanner driving a VGA DAC.
// The counter/address stage feeds a registered-read RAM; outputs trail by one pixel tick.
module vga_frame_scanner #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        pixel_enable,
    output logic [18:0] mem_raddr,
    input  logic [2:0]  mem_rdata,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic        vga_blank_n,
    output logic        vga_sync_n,
    output logic [7:0]  vga_r,
    output logic [7:0]  vga_g,
    output logic [7:0]  vga_b,
    output logic        frame_start,
    output logic        vblank
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW = $clog2(H_TOTAL);
    localparam int VW = $clog2(V_TOTAL);
    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);

    logic [HW-1:0] r_h, w_h_nxt;
    logic [VW-1:0] r_v, w_v_nxt;
    logic [18:0]   r_addr;
    logic          r_hs, r_vs, r_blank_n;
    logic [7:0]    r_r, r_g, r_b;
    logic          w_h_last, w_v_last, w_active, w_nxt_active, w_wrap;

    always_comb begin
        w_h_last     = r_h == H_LAST;
        w_v_last     = r_v == V_LAST;
        w_h_nxt      = w_h_last ? '0 : r_h + HW'(1);
        w_v_nxt      = !w_h_last ? r_v : (w_v_last ? '0 : r_v + VW'(1));
        w_active     = (r_h < H_ACT) && (r_v < V_ACT);
        w_nxt_active = (w_h_nxt < H_ACT) && (w_v_nxt < V_ACT);
        w_wrap       = pixel_enable && w_h_last && w_v_last;
    end

    // Address advances only when the next position is visible, so it parks on the last visible index in blanking
    always_ff @(posedge clock) begin
        if (reset) begin
            r_h       <= '0;
            r_v       <= '0;
            r_addr    <= '0;
            r_hs      <= 1'b1;
            r_vs      <= 1'b1;
            r_blank_n <= 1'b0;
            r_r       <= '0;
            r_g       <= '0;
            r_b       <= '0;
        end else if (pixel_enable) begin
            r_h       <= w_h_nxt;
            r_v       <= w_v_nxt;
            r_addr    <= w_wrap ? '0 : (w_nxt_active ? r_addr + 19'd1 : r_addr);
            r_hs      <= !((r_h >= HS_BEG) && (r_h < HS_END));
            r_vs      <= !((r_v >= VS_BEG) && (r_v < VS_END));
            r_blank_n <= w_active;
            r_r       <= {8{w_active & mem_rdata[2]}};
            r_g       <= {8{w_active & mem_rdata[1]}};
            r_b       <= {8{w_active & mem_rdata[0]}};
        end
    end

    assign mem_raddr   = r_addr;
    assign vga_hs      = r_hs;
    assign vga_vs      = r_vs;
    assign vga_blank_n = r_blank_n;
    assign vga_sync_n  = 1'b0;
    assign vga_r       = r_r;
    assign vga_g       = r_g;
    assign vga_b       = r_b;
    assign frame_start = w_wrap && !reset;
    assign vblank      = r_v >= V_ACT;
endmodule
